// File: rtl/return_address_stack.sv
// Circular return-address stack with non-destructive pops and pipeline-flush rollback.
// Optional overflow/underflow statistics counters are built when RAS_STATS_EN is defined.
module return_address_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RAS_push,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             RAS_pop,
  input  logic             RAS_rollback_pop_id,
  input  logic             RAS_rollback_push_id,
  input  logic             RAS_rollback_push_ex,
  input  logic             WR_ra_track_en,
  input  logic [4:0]       WR_ra_track_data,
  output logic [WIDTH-1:0] RAS_top,
  output logic             RAS_valid,
  output logic             RAS_full,
  output logic [4:0]       RAS_ra_track,
  output logic [15:0]      ovf_cnt,
  output logic [15:0]      unf_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = PTR_W + 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] entry [DEPTH];
  logic [PTR_W-1:0] tp, tp_nxt, tp_dec, wr_idx;
  logic [CNT_W-1:0] count, count_nxt;
  logic [4:0]       ra_track, ra_nxt;
  logic [SUM_W-1:0] rb_up, rb_sum;
  logic             rollback, is_full, is_empty, wr_en;

  // Next-state decode: rollback has priority over push/pop
  always_comb begin
    rollback  = RAS_rollback_pop_id | RAS_rollback_push_id | RAS_rollback_push_ex;
    is_full   = (count == FULL_CNT);
    is_empty  = (count == '0);
    tp_dec    = tp - PTR_W'(1);
    tp_nxt    = tp;
    count_nxt = count;
    wr_en     = 1'b0;
    wr_idx    = tp;
    ra_nxt    = ra_track;
    rb_up     = SUM_W'(count) + SUM_W'(RAS_rollback_push_id) + SUM_W'(RAS_rollback_push_ex);
    rb_sum    = rb_up;

    if (rollback) begin
      tp_nxt = tp + PTR_W'(RAS_rollback_push_id) + PTR_W'(RAS_rollback_push_ex)
                  - PTR_W'(RAS_rollback_pop_id);
      if (RAS_rollback_pop_id && (rb_up != '0)) rb_sum = rb_up - SUM_W'(1);
      count_nxt = (rb_sum > SUM_W'(DEPTH)) ? FULL_CNT : CNT_W'(rb_sum);
    end else if (RAS_push && RAS_pop && !is_empty) begin
      wr_en  = 1'b1;
      wr_idx = tp_dec;
    end else if (RAS_push) begin
      wr_en  = 1'b1;
      tp_nxt = tp + PTR_W'(1);
      if (!is_full) count_nxt = count + CNT_W'(1);
    end else if (RAS_pop && !is_empty) begin
      tp_nxt    = tp_dec;
      count_nxt = count - CNT_W'(1);
    end

    if (RAS_push)            ra_nxt = 5'd1;
    else if (WR_ra_track_en) ra_nxt = WR_ra_track_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp       <= '0;
      count    <= '0;
      ra_track <= 5'd1;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else begin
      tp       <= tp_nxt;
      count    <= count_nxt;
      ra_track <= ra_nxt;
      if (wr_en) entry[wr_idx] <= push_addr;
    end
  end

  assign RAS_top      = entry[tp_dec];
  assign RAS_valid    = !is_empty;
  assign RAS_full     = is_full;
  assign RAS_ra_track = ra_track;

`ifdef RAS_STATS_EN
  logic ovf_inc, unf_inc;
  assign ovf_inc = !rollback && RAS_push && !RAS_pop && is_full;
  assign unf_inc = !rollback && RAS_pop && !RAS_push && is_empty;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (ovf_inc && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
      if (unf_inc && (unf_cnt != 16'hFFFF)) unf_cnt <= unf_cnt + 16'd1;
    end
  end
`else
  assign ovf_cnt = '0;
  assign unf_cnt = '0;
`endif

endmodule

// File: tb/tb_return_address_stack.sv
// Directed testbench for return_address_stack (DEPTH=8, WIDTH=32).
module tb_return_address_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RAS_push = 1'b0;
  logic [31:0] push_addr = '0;
  logic        RAS_pop = 1'b0;
  logic        RAS_rollback_pop_id = 1'b0;
  logic        RAS_rollback_push_id = 1'b0;
  logic        RAS_rollback_push_ex = 1'b0;
  logic        WR_ra_track_en = 1'b0;
  logic [4:0]  WR_ra_track_data = '0;
  logic [31:0] RAS_top;
  logic        RAS_valid;
  logic        RAS_full;
  logic [4:0]  RAS_ra_track;
  logic [15:0] ovf_cnt;
  logic [15:0] unf_cnt;

  int total = 0;
  int bad = 0;

`ifdef RAS_STATS_EN
  localparam logic [15:0] STAT1 = 16'd1;
`else
  localparam logic [15:0] STAT1 = 16'd0;
`endif

  return_address_stack #(.DEPTH(8), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .RAS_push(RAS_push), .push_addr(push_addr), .RAS_pop(RAS_pop),
    .RAS_rollback_pop_id(RAS_rollback_pop_id),
    .RAS_rollback_push_id(RAS_rollback_push_id),
    .RAS_rollback_push_ex(RAS_rollback_push_ex),
    .WR_ra_track_en(WR_ra_track_en), .WR_ra_track_data(WR_ra_track_data),
    .RAS_top(RAS_top), .RAS_valid(RAS_valid), .RAS_full(RAS_full),
    .RAS_ra_track(RAS_ra_track), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of strobes, let the edge take them, then return to idle.
  task automatic apply(input logic push, input logic [31:0] addr, input logic pop,
                       input logic rb_pop_id, input logic rb_push_id, input logic rb_push_ex,
                       input logic wr, input logic [4:0] wr_data);
    RAS_push = push; push_addr = addr; RAS_pop = pop;
    RAS_rollback_pop_id = rb_pop_id; RAS_rollback_push_id = rb_push_id;
    RAS_rollback_push_ex = rb_push_ex;
    WR_ra_track_en = wr; WR_ra_track_data = wr_data;
    @(posedge clk); #1;
    RAS_push = 1'b0; push_addr = '0; RAS_pop = 1'b0;
    RAS_rollback_pop_id = 1'b0; RAS_rollback_push_id = 1'b0; RAS_rollback_push_ex = 1'b0;
    WR_ra_track_en = 1'b0; WR_ra_track_data = '0;
  endtask

  task automatic do_push(input logic [31:0] addr);
    apply(1'b1, addr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic do_pop();
    apply(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (RAS_top !== 32'h0) begin bad++; $display("FAIL reset_top got=%h exp=%h", RAS_top, 32'h0); end
    total++; if (RAS_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", RAS_valid); end
    total++; if (RAS_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", RAS_full); end
    total++; if (RAS_ra_track !== 5'd1) begin bad++; $display("FAIL reset_ra got=%0d exp=1", RAS_ra_track); end
    total++; if (ovf_cnt !== 16'd0 || unf_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", ovf_cnt, unf_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    total++; if (RAS_top !== 32'h300) begin bad++; $display("FAIL basic_top3 got=%h exp=300", RAS_top); end
    total++; if (RAS_valid !== 1'b1 || RAS_full !== 1'b0) begin
      bad++; $display("FAIL basic_flags got=v%b f%b exp=v1 f0", RAS_valid, RAS_full); end
    do_pop(); do_pop();
    total++; if (RAS_top !== 32'h100) begin bad++; $display("FAIL basic_pop2 got=%h exp=100", RAS_top); end
    total++; if (RAS_valid !== 1'b1) begin bad++; $display("FAIL basic_valid1 got=%b exp=1", RAS_valid); end
    do_pop();
    total++; if (RAS_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", RAS_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) do_push(32'(i * 16));
    total++; if (RAS_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", RAS_full); end
    total++; if (RAS_top !== 32'h90) begin bad++; $display("FAIL ovf_top got=%h exp=90", RAS_top); end
    total++; if (ovf_cnt !== STAT1) begin bad++; $display("FAIL ovf_cnt got=%0d exp=%0d", ovf_cnt, STAT1); end
    for (int i = 0; i < 7; i++) do_pop();
    total++; if (RAS_top !== 32'h20 || RAS_valid !== 1'b1) begin
      bad++; $display("FAIL ovf_last_top got=%h v%b exp=20 v1", RAS_top, RAS_valid); end
    do_pop();
    total++; if (RAS_valid !== 1'b0 || RAS_full !== 1'b0) begin
      bad++; $display("FAIL ovf_drained got=v%b f%b exp=v0 f0", RAS_valid, RAS_full); end
    // Clamp: rollback push on a full stack keeps it full
    do_reset();
    for (int i = 1; i <= 8; i++) do_push(32'(i));
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    total++; if (RAS_full !== 1'b1 || RAS_top !== 32'h1) begin
      bad++; $display("FAIL clamp_full got=f%b top=%h exp=f1 top=1", RAS_full, RAS_top); end
  endtask

  task automatic test_rollback_push();
    do_reset();
    do_push(32'hA0); do_push(32'hB0);
    do_pop(); do_pop();
    total++; if (RAS_valid !== 1'b0) begin bad++; $display("FAIL rbp_empty got=%b exp=0", RAS_valid); end
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    total++; if (RAS_top !== 32'hB0 || RAS_valid !== 1'b1) begin
      bad++; $display("FAIL rbp_top got=%h v%b exp=b0 v1", RAS_top, RAS_valid); end
    do_pop();
    total++; if (RAS_top !== 32'hA0 || RAS_valid !== 1'b1) begin
      bad++; $display("FAIL rbp_cnt2 got=%h v%b exp=a0 v1", RAS_top, RAS_valid); end
    do_pop();
    total++; if (RAS_valid !== 1'b0) begin bad++; $display("FAIL rbp_cnt0 got=%b exp=0", RAS_valid); end
  endtask

  task automatic test_rollback_pop();
    do_reset();
    do_push(32'h50); do_push(32'hC0);
    total++; if (RAS_top !== 32'hC0) begin bad++; $display("FAIL rbo_pre got=%h exp=c0", RAS_top); end
    // Rollback pop with a concurrent push: the push must be ignored
    apply(1'b1, 32'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    total++; if (RAS_top !== 32'h50) begin bad++; $display("FAIL rbo_top got=%h exp=50", RAS_top); end
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    total++; if (RAS_top !== 32'hC0) begin bad++; $display("FAIL rbo_restore got=%h exp=c0", RAS_top); end
    do_pop(); do_pop();
    total++; if (RAS_valid !== 1'b0) begin bad++; $display("FAIL rbo_count got=%b exp=0", RAS_valid); end
    // Clamp at zero: rollback pop on empty stack leaves it empty
    apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    total++; if (RAS_valid !== 1'b0) begin bad++; $display("FAIL rbo_clamp0 got=%b exp=0", RAS_valid); end
  endtask

  task automatic test_underflow_swap();
    do_reset();
    do_pop();
    total++; if (RAS_valid !== 1'b0 || RAS_top !== 32'h0) begin
      bad++; $display("FAIL unf_state got=v%b top=%h exp=v0 top=0", RAS_valid, RAS_top); end
    total++; if (unf_cnt !== STAT1) begin bad++; $display("FAIL unf_cnt got=%0d exp=%0d", unf_cnt, STAT1); end
    do_push(32'h11); do_push(32'h22);
    apply(1'b1, 32'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    total++; if (RAS_top !== 32'h33) begin bad++; $display("FAIL swap_top got=%h exp=33", RAS_top); end
    do_pop();
    total++; if (RAS_top !== 32'h11 || RAS_valid !== 1'b1) begin
      bad++; $display("FAIL swap_cnt got=%h v%b exp=11 v1", RAS_top, RAS_valid); end
    do_pop();
    // Push+pop on empty behaves as push only
    apply(1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    total++; if (RAS_top !== 32'h77 || RAS_valid !== 1'b1) begin
      bad++; $display("FAIL swap_empty got=%h v%b exp=77 v1", RAS_top, RAS_valid); end
  endtask

  task automatic test_ra_track();
    do_reset();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    total++; if (RAS_ra_track !== 5'd5) begin bad++; $display("FAIL ra_wr got=%0d exp=5", RAS_ra_track); end
    apply(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    total++; if (RAS_ra_track !== 5'd1) begin bad++; $display("FAIL ra_push_wins got=%0d exp=1", RAS_ra_track); end
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
    total++; if (RAS_ra_track !== 5'd9 || RAS_top !== 32'h44) begin
      bad++; $display("FAIL ra_wr9 got=%0d top=%h exp=9 top=44", RAS_ra_track, RAS_top); end
    // Async reset mid-cycle, sampled before any clock edge
    rst_n = 1'b0;
    #1;
    total++; if (RAS_top !== 32'h0 || RAS_valid !== 1'b0 || RAS_full !== 1'b0 || RAS_ra_track !== 5'd1) begin
      bad++; $display("FAIL async_rst got=top%h v%b f%b ra%0d exp=top0 v0 f0 ra1",
                      RAS_top, RAS_valid, RAS_full, RAS_ra_track); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_rollback_push();
    test_rollback_pop();
    test_underflow_swap();
    test_ra_track();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
